// File: rtl/axi_imem_slave.sv
// axi_imem_slave: read-only AXI4 instruction memory for the instruction-fetch port.
// Serves FIXED/INCR/WRAP read bursts at one beat per cycle from a word array that
// is loaded through a side programming port. Writes are accepted and drained but
// always answered with SLVERR so a stray write cannot hang the bus.
module axi_imem_slave #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
    input  logic [7:0]                   s_axi_arlen,
    input  logic [2:0]                   s_axi_arsize,
    input  logic [1:0]                   s_axi_arburst,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [3:0]                   s_axi_rid,
    output logic [DATA_WIDTH-1:0]        s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rlast,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    input  logic [3:0]                   s_axi_awid,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic                         s_axi_wlast,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    output logic [3:0]                   s_axi_bid,
    output logic [1:0]                   s_axi_bresp,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    input  logic                         prog_we,
    input  logic [$clog2(MEM_WORDS)-1:0] prog_addr,
    input  logic [DATA_WIDTH-1:0]        prog_wdata
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR_DATA,
        WR_RESP
    } state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    state_t state_q;
    state_t state_d;

    logic [3:0]            rid_q;
    logic [3:0]            bid_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_q;
    logic [1:0]            burst_q;
    logic [2:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    logic                  wrap_en;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [2:0]            rd_size;
    logic [ADDR_WIDTH:0]   rd_diff;
    logic [ADDR_WIDTH-1:0] rd_word;
    logic                  rd_in_range;
    logic [IDX_W-1:0]      rd_idx;

    logic last_beat;
    logic ar_hs;
    logic r_hs;
    logic aw_hs;
    logic load;

    assign last_beat = (beat_q == len_q);
    assign ar_hs     = s_axi_arvalid && s_axi_arready;
    assign r_hs      = s_axi_rvalid && s_axi_rready;
    assign aw_hs     = s_axi_awvalid && s_axi_awready;
    assign load      = ar_hs || (r_hs && !last_beat);

    // Address of the beat after the one currently presented, per burst type.
    // WRAP only applies to 2/4/8/16-beat bursts; other lengths fall back to INCR.
    always_comb begin
        wrap_en   = (burst_q == BURST_WRAP) &&
                    (len_q == 8'd1 || len_q == 8'd3 || len_q == 8'd7 || len_q == 8'd15);
        wrap_mask = ADDR_WIDTH'({len_q, 2'b11});
        next_addr = addr_q + ADDR_WIDTH'(4);
        if (burst_q == BURST_FIXED) begin
            next_addr = addr_q;
        end else if (wrap_en) begin
            next_addr = (addr_q & ~wrap_mask) | ((addr_q + ADDR_WIDTH'(4)) & wrap_mask);
        end
    end

    // Decode the address being fetched this cycle: the AR start address when idle,
    // otherwise the prefetch address for the next beat. The borrow bit of the
    // subtraction flags addresses below BASE_ADDR.
    always_comb begin
        rd_addr     = (state_q == IDLE) ? s_axi_araddr : next_addr;
        rd_size     = (state_q == IDLE) ? s_axi_arsize : size_q;
        rd_diff     = {1'b0, rd_addr} - {1'b0, BASE_ADDR};
        rd_word     = rd_diff[ADDR_WIDTH-1:0] >> 2;
        rd_in_range = !rd_diff[ADDR_WIDTH] && (rd_word < ADDR_WIDTH'(MEM_WORDS));
        rd_idx      = rd_word[IDX_W-1:0];
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and bus outputs; everything is forced low while rst is high.
    always_comb begin
        state_d       = state_q;
        s_axi_arready = 1'b0;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rid     = '0;
        s_axi_rdata   = '0;
        s_axi_rresp   = '0;
        s_axi_rlast   = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bid     = '0;
        s_axi_bresp   = '0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    s_axi_arready = 1'b1;
                    s_axi_awready = !s_axi_arvalid;
                    if (s_axi_arvalid) begin
                        state_d = RD;
                    end else if (s_axi_awvalid) begin
                        state_d = WR_DATA;
                    end
                end
                RD: begin
                    s_axi_rvalid = 1'b1;
                    s_axi_rid    = rid_q;
                    s_axi_rdata  = rdata_q;
                    s_axi_rresp  = rresp_q;
                    s_axi_rlast  = last_beat;
                    if (s_axi_rready && last_beat) begin
                        state_d = IDLE;
                    end
                end
                WR_DATA: begin
                    s_axi_wready = 1'b1;
                    if (s_axi_wvalid && s_axi_wlast) begin
                        state_d = WR_RESP;
                    end
                end
                WR_RESP: begin
                    s_axi_bvalid = 1'b1;
                    s_axi_bid    = bid_q;
                    s_axi_bresp  = RESP_SLVERR;
                    if (s_axi_bready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Burst bookkeeping and the registered array read. A new word is fetched on the
    // AR handshake and on every non-final R handshake so beats flow without bubbles;
    // while the master stalls, nothing here changes and the beat is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            rid_q   <= '0;
            bid_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            burst_q <= '0;
            size_q  <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            rresp_q <= '0;
        end else begin
            if (ar_hs) begin
                rid_q   <= s_axi_arid;
                len_q   <= s_axi_arlen;
                burst_q <= s_axi_arburst;
                size_q  <= s_axi_arsize;
                addr_q  <= s_axi_araddr;
                beat_q  <= '0;
            end else if (r_hs && !last_beat) begin
                addr_q <= next_addr;
                beat_q <= beat_q + 8'd1;
            end
            if (load) begin
                if (rd_size != 3'd2) begin
                    rresp_q <= RESP_SLVERR;
                    rdata_q <= '0;
                end else if (!rd_in_range) begin
                    rresp_q <= RESP_DECERR;
                    rdata_q <= '0;
                end else begin
                    rresp_q <= RESP_OKAY;
                    rdata_q <= mem[rd_idx];
                end
            end
            if (aw_hs) begin
                bid_q <= s_axi_awid;
            end
        end
    end

    // Programming port; no reset so the loaded program survives rst.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

endmodule

// File: tb/tb_axi_imem_slave.sv
// tb_axi_imem_slave: scoreboard bench for axi_imem_slave. Read stimulus pushes the
// beats a word-array reference model predicts; a monitor pops and compares them as
// R handshakes happen, and does the same for B responses.
module tb_axi_imem_slave;

    localparam int          MEM_WORDS = 1024;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  s_axi_arid = '0;
    logic [31:0] s_axi_araddr = '0;
    logic [7:0]  s_axi_arlen = '0;
    logic [2:0]  s_axi_arsize = '0;
    logic [1:0]  s_axi_arburst = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [3:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b1;
    logic [3:0]  s_axi_awid = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic        s_axi_wlast = 1'b0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [3:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b1;
    logic        prog_we = 1'b0;
    logic [9:0]  prog_addr = '0;
    logic [31:0] prog_wdata = '0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [3:0]  id;
        logic        last;
    } beat_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    beat_t       sb[$];
    bexp_t       bsb[$];
    logic [31:0] model_mem [MEM_WORDS];
    int          rr_pattern[$];
    bit          rand_rready = 1'b0;
    int          checks = 0;
    int          errors = 0;

    axi_imem_slave #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .MEM_WORDS (MEM_WORDS),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axi_arid   (s_axi_arid),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arlen  (s_axi_arlen),
        .s_axi_arsize (s_axi_arsize),
        .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rid    (s_axi_rid),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rlast  (s_axi_rlast),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .s_axi_awid   (s_axi_awid),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wlast  (s_axi_wlast),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_bid    (s_axi_bid),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_wdata   (prog_wdata)
    );

    // Free-running 10 ns clock.
    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    task automatic flagFailure(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got timeout, required handshake", name);
    endtask

    // Reference model: beat addresses and responses straight from the burst rules.
    function automatic void pushRead(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
        int unsigned bytes;
        bit          wrap;
        logic [31:0] a;
        logic [31:0] base;
        longint      off;
        beat_t       b;
        bytes = (int'(len) + 1) * 4;
        wrap  = (burst == 2'b10) && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        for (int i = 0; i <= int'(len); i++) begin
            if (burst == 2'b00) begin
                a = addr;
            end else if (wrap) begin
                base = addr - (addr % bytes);
                a    = base + ((addr - base + 32'(4 * i)) % bytes);
            end else begin
                a = addr + 32'(4 * i);
            end
            off    = longint'(a) - longint'(BASE_ADDR);
            b.id   = id;
            b.last = (i == int'(len));
            if (size != 3'd2) begin
                b.resp = 2'b10;
                b.data = '0;
            end else if (off >= 0 && (off / 4) < MEM_WORDS) begin
                b.resp = 2'b00;
                b.data = model_mem[int'(off / 4)];
            end else begin
                b.resp = 2'b11;
                b.data = '0;
            end
            sb.push_back(b);
        end
    endfunction

    task automatic progWord(input int idx, input logic [31:0] data);
        prog_we    = 1'b1;
        prog_addr  = 10'(idx);
        prog_wdata = data;
        @(posedge clk); #1;
        prog_we        = 1'b0;
        model_mem[idx] = data;
    endtask

    // Issue one AR. Optionally writes the array in the same cycle as the handshake
    // and/or checks that a concurrent AW is held off.
    task automatic applyStimulus(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                                 input logic [2:0] size, input logic [1:0] burst,
                                 input bit prog_same = 1'b0, input int prog_idx = 0,
                                 input logic [31:0] prog_data = '0, input bit aw_blocked = 1'b0);
        bit hs;
        pushRead(id, addr, len, size, burst);
        s_axi_arid    = id;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arsize  = size;
        s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        if (prog_same) begin
            prog_we    = 1'b1;
            prog_addr  = 10'(prog_idx);
            prog_wdata = prog_data;
        end
        hs = 1'b0;
        for (int c = 0; c < 50 && !hs; c++) begin
            @(negedge clk);
            hs = s_axi_arready;
            if (aw_blocked) checkOutput("awready_lost_arbitration", 32'(s_axi_awready), 32'd0);
            @(posedge clk); #1;
            if (prog_same) begin
                prog_we             = 1'b0;
                model_mem[prog_idx] = prog_data;
                prog_same           = 1'b0;
            end
        end
        s_axi_arvalid = 1'b0;
        if (!hs) flagFailure("ar_handshake");
        else     checkOutput("rvalid_one_cycle_after_ar", 32'(s_axi_rvalid), 32'd1);
    endtask

    task automatic waitReadDrain();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(posedge clk); #1;
            done = (sb.size() == 0);
        end
        if (!done) begin
            flagFailure("read_burst_drain");
            sb.delete();
        end else begin
            checkOutput("arready_after_last", 32'(s_axi_arready), 32'd1);
            checkOutput("rvalid_after_last", 32'(s_axi_rvalid), 32'd0);
        end
    endtask

    task automatic doWrite(input logic [3:0] id, input int nbeats);
        bit    hs;
        bexp_t e;
        s_axi_awid    = id;
        s_axi_awvalid = 1'b1;
        hs = 1'b0;
        for (int c = 0; c < 50 && !hs; c++) begin
            @(negedge clk);
            hs = s_axi_awready;
            @(posedge clk); #1;
        end
        s_axi_awvalid = 1'b0;
        if (!hs) begin
            flagFailure("aw_handshake");
            return;
        end
        checkOutput("arready_in_write", 32'(s_axi_arready), 32'd0);
        e.id   = id;
        e.resp = 2'b10;
        bsb.push_back(e);
        for (int k = 0; k < nbeats; k++) begin
            s_axi_wvalid = 1'b1;
            s_axi_wlast  = (k == nbeats - 1);
            hs = 1'b0;
            for (int c = 0; c < 50 && !hs; c++) begin
                @(negedge clk);
                hs = s_axi_wready;
                @(posedge clk); #1;
            end
            if (!hs) flagFailure("w_handshake");
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        hs = 1'b0;
        for (int c = 0; c < 50 && !hs; c++) begin
            @(posedge clk); #1;
            hs = (bsb.size() == 0);
        end
        if (!hs) begin
            flagFailure("b_response");
            bsb.delete();
        end
    endtask

    // rready driver: a queued pattern while a burst is live, else random or held high.
    initial forever begin
        @(posedge clk); #1;
        if (rr_pattern.size() > 0 && s_axi_rvalid) s_axi_rready = 1'(rr_pattern.pop_front());
        else if (rand_rready)                      s_axi_rready = 1'($urandom_range(0, 1));
        else                                       s_axi_rready = 1'b1;
    end

    // Monitor: compare every R and B handshake against the scoreboard heads.
    initial forever begin
        beat_t b;
        bexp_t e;
        @(negedge clk);
        if (s_axi_rvalid && s_axi_rready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL r_unexpected: got beat rdata=0x%08h, required no beat", s_axi_rdata);
            end else begin
                b = sb.pop_front();
                checkOutput("rdata", s_axi_rdata, b.data);
                checkOutput("rresp", 32'(s_axi_rresp), 32'(b.resp));
                checkOutput("rid",   32'(s_axi_rid), 32'(b.id));
                checkOutput("rlast", 32'(s_axi_rlast), 32'(b.last));
            end
        end
        if (s_axi_bvalid && s_axi_bready) begin
            if (bsb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL b_unexpected: got bid=%0d, required no response", s_axi_bid);
            end else begin
                e = bsb.pop_front();
                checkOutput("bid",   32'(s_axi_bid), 32'(e.id));
                checkOutput("bresp", 32'(s_axi_bresp), 32'(e.resp));
            end
        end
    end

    // Hard stop in case the bench itself wedges.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        logic [31:0] a;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          wl;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("reset_arready", 32'(s_axi_arready), 32'd0);
        checkOutput("reset_awready", 32'(s_axi_awready), 32'd0);
        checkOutput("reset_rvalid",  32'(s_axi_rvalid), 32'd0);
        checkOutput("reset_bvalid",  32'(s_axi_bvalid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("idle_arready", 32'(s_axi_arready), 32'd1);
        checkOutput("idle_awready", 32'(s_axi_awready), 32'd1);

        $display("[TB] preloading array");
        for (int i = 0; i < MEM_WORDS; i++) begin
            if (i < 4)       progWord(i, 32'(11 * (i + 1)));
            else if (i == 4) progWord(i, 32'h1234_5678);
            else             progWord(i, $urandom);
        end

        $display("[TB] INCR and WRAP bursts");
        applyStimulus(4'd5, 32'h0, 8'd3, 3'd2, 2'b01);
        waitReadDrain();
        applyStimulus(4'd3, 32'h8, 8'd3, 3'd2, 2'b10);
        waitReadDrain();
        rr_pattern = '{1, 0, 0, 1};
        applyStimulus(4'd3, 32'h8, 8'd3, 3'd2, 2'b10);
        waitReadDrain();
        rr_pattern.delete();

        $display("[TB] range and size errors");
        applyStimulus(4'd7, BASE_ADDR + 32'((MEM_WORDS - 2) * 4), 8'd3, 3'd2, 2'b01);
        waitReadDrain();
        applyStimulus(4'd2, 32'h10, 8'd1, 3'd1, 2'b01);
        waitReadDrain();
        applyStimulus(4'd6, 32'h1C, 8'd2, 3'd2, 2'b00);
        waitReadDrain();

        $display("[TB] AR/AW contention and write path");
        s_axi_awid    = 4'd9;
        s_axi_awvalid = 1'b1;
        applyStimulus(4'd1, 32'h0, 8'd1, 3'd2, 2'b01, 1'b0, 0, '0, 1'b1);
        waitReadDrain();
        doWrite(4'd9, 3);
        applyStimulus(4'd4, 32'h0, 8'd3, 3'd2, 2'b01);
        waitReadDrain();

        $display("[TB] reset mid-burst");
        applyStimulus(4'd8, 32'h0, 8'd7, 3'd2, 2'b01);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_rvalid_same_cycle", 32'(s_axi_rvalid), 32'd0);
        checkOutput("rst_arready", 32'(s_axi_arready), 32'd0);
        checkOutput("rst_awready", 32'(s_axi_awready), 32'd0);
        @(posedge clk); #1;
        checkOutput("rst_rvalid_next_cycle", 32'(s_axi_rvalid), 32'd0);
        checkOutput("rst_arready_held", 32'(s_axi_arready), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("post_rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        checkOutput("post_rst_arready", 32'(s_axi_arready), 32'd1);
        applyStimulus(4'd1, 32'h0, 8'd0, 3'd2, 2'b01);
        waitReadDrain();

        $display("[TB] programming port collision");
        applyStimulus(4'd2, 32'h10, 8'd0, 3'd2, 2'b01, 1'b1, 4, 32'h0000_DEAD);
        waitReadDrain();
        applyStimulus(4'd2, 32'h10, 8'd0, 3'd2, 2'b01);
        waitReadDrain();

        $display("[TB] randomized bursts");
        rand_rready = 1'b1;
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 2) == 0) progWord(int'($urandom_range(0, MEM_WORDS - 1)), $urandom);
            burst = 2'($urandom_range(0, 2));
            if (burst == 2'b10 && $urandom_range(0, 3) != 0) begin
                wl  = $urandom_range(0, 3);
                len = 8'((2 << wl) - 1);
            end else begin
                len = 8'($urandom_range(0, 15));
            end
            size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            a    = 32'($urandom_range(0, MEM_WORDS * 4 + 48));
            applyStimulus(4'($urandom_range(0, 15)), a, len, size, burst);
            waitReadDrain();
        end
        rand_rready = 1'b0;

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_imem_slave.md
Name: axi_imem_slave

Overview:
- Read-only AXI4 slave instruction memory that sits directly downstream of the CPU complex instruction-fetch master port (m_axi_if_*) and serves its burst fetches.
- Holds a word array that is loaded through a side programming port before or between fetches.
- Returns INCR, FIXED and WRAP read bursts at one beat per cycle.
- The write channels are fully handshaken and always answered with SLVERR, so a stray write from the fetch port never hangs the bus.

Parameters:
DATA_WIDTH, 32, data bus width; only 32 is supported.
ADDR_WIDTH, 32, AXI address width.
MEM_WORDS, 1024, number of 32-bit words in the array (power of two).
BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
s_axi_arid  in  4  read ID
s_axi_araddr  in  ADDR_WIDTH  read start byte address
s_axi_arlen  in  8  beats minus 1
s_axi_arsize  in  3  beat size
s_axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP
s_axi_arvalid / s_axi_arready  in / out  1 / 1  AR handshake
s_axi_rid  out  4  echoed arid
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
s_axi_rlast  out  1  final beat
s_axi_rvalid / s_axi_rready  out / in  1 / 1  R handshake
s_axi_awid  in  4  write ID
s_axi_awvalid / s_axi_awready  in / out  1 / 1  AW handshake
s_axi_wlast  in  1  final write beat
s_axi_wvalid / s_axi_wready  in / out  1 / 1  W handshake (data ignored)
s_axi_bid  out  4  echoed awid
s_axi_bresp  out  2  always 10
s_axi_bvalid / s_axi_bready  out / in  1 / 1  B handshake
prog_we  in  1  array write strobe
prog_addr  in  $clog2(MEM_WORDS)  word index
prog_wdata  in  DATA_WIDTH  word to write

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst).
- While rst=1:
  - state returns to IDLE.
  - All outputs are 0, including arready and awready.
  - Array contents are preserved.
- Reset mid-burst aborts the burst: rvalid/bvalid are 0 on the cycle after rst is sampled high, and no further beats are sent.
- FSM states: IDLE, RD, WR_DATA, WR_RESP. Only one transaction is outstanding at a time.
- IDLE:
  - arready = awready = 1 (combinational from state, gated by !rst).
  - If arvalid and awvalid are both high in the same cycle, the read wins: awready is 0 that cycle.
  - AR handshake -> RD. Latch arid, arlen, arburst, arsize and the start address.
- RD:
  - First rvalid is asserted exactly 1 cycle after the AR handshake. The array read is synchronous (registered).
  - rdata, rresp, rid and rlast are held stable while rvalid=1 and rready=0.
  - While rready stays 1, one beat is sent per cycle with no bubbles. The next beat is prefetched on each handshake.
  - rlast = 1 only on beat number arlen.
  - After the last handshake -> IDLE. arready is 1 on the following cycle.
- Beat address:
  - FIXED: the start address on every beat.
  - INCR: +4 per beat; the 4 KB boundary is not checked.
  - WRAP: wraps inside the aligned (arlen+1)*4-byte window. Legal arlen values are 1, 3, 7 and 15. Any other arlen behaves as INCR.
- Address decode, per beat:
  - idx = (addr - BASE_ADDR) >> 2.
  - Address bits [1:0] are ignored.
  - in_range = (addr >= BASE_ADDR) and (idx < MEM_WORDS).
- Response, per beat:
  - arsize != 2: SLVERR with rdata 0 on every beat; beat count is still arlen+1.
  - Otherwise, !in_range: DECERR with rdata 0.
  - Otherwise: OKAY with mem[idx].
- Write path:
  - AW handshake -> WR_DATA, with wready = 1.
  - W beats are consumed until a handshake with wlast=1 -> WR_RESP.
  - WR_RESP: bvalid = 1, bid = latched awid, bresp = 10. On bready -> IDLE.
- Programming port: prog_we writes mem[prog_addr] at the clock edge, in any state.
  - A same-cycle array read of the same index returns the old word.
  - The new word is visible to the next read.

Test Plan:
- Preload mem[0..3] = 11,22,33,44. Send INCR, araddr 0x0, arlen 3, arsize 2, arid 5, rready held 1 -> rvalid 1 cycle after AR; 4 consecutive beats 11,22,33,44, all OKAY, rid 5; rlast only on beat 4; arready high the next cycle.
- WRAP, araddr 0x8, arlen 3 -> beats mem[2],mem[3],mem[0],mem[1]. Same burst with rready toggling 1,0,0,1 -> data held stable and no beat lost or duplicated.
- INCR, araddr = BASE_ADDR + (MEM_WORDS-2)*4, arlen 3 -> OKAY,OKAY,DECERR,DECERR; beats 3-4 rdata 0. arsize 1, arlen 1 -> 2 beats of SLVERR.
- arvalid and awvalid asserted in the same IDLE cycle -> read served first. Then awid 9 with 3 W beats (wlast on beat 3) -> bvalid with bid 9, bresp 10; no change to array contents.
- rst asserted during beat 2 of an 8-beat INCR -> rvalid 0 on the next cycle and arready 0 while rst=1. After release, a fresh read of mem[0] returns the preloaded value.
- prog_we writes mem[4] = 0xDEAD in the same cycle as its read -> old value returned. Re-read -> 0xDEAD.
